// File: rtl/eros_obi_pkg.sv
// rtl/eros_obi_pkg.sv - OBI request/response bus types
package eros_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/eros_pkg.sv
// rtl/eros_pkg.sv - shared lockstep types
package eros_pkg;

    typedef enum logic [1:0] {
        RSP_RUN   = 2'd0,
        RSP_DRAIN = 2'd1,
        RSP_HALT  = 2'd2
    } dmr_rsp_state_e;

endpackage

// File: rtl/dmr_outstanding_cnt.sv
// rtl/dmr_outstanding_cnt.sv - per-bus outstanding transaction counter
module dmr_outstanding_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o,
    output logic          zero_next_o,
    output logic          spurious_o,
    output logic          overflow_o
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign spurious_o = dec_i && (count_q == '0);
    assign overflow_o = inc_i && !dec_i && (count_q == MAX_C);

    // A spurious rvalid pins the count at zero; overflow saturates it.
    always_comb begin
        count_d = count_q;
        if (spurious_o) begin
            count_d = '0;
        end else if (overflow_o) begin
            count_d = count_q;
        end else if (inc_i && !dec_i) begin
            count_d = count_q + CW'(1);
        end else if (dec_i && !inc_i) begin
            count_d = count_q - CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign zero_o      = (count_q == '0);
    assign zero_next_o = (count_d == '0);

endmodule

// File: rtl/dmr_response_distributor.sv
// rtl/dmr_response_distributor.sv - fan bus responses out to lockstep harts, drain on fault
module dmr_response_distributor
    import eros_obi_pkg::*;
    import eros_pkg::*;
#(
    parameter int unsigned NHARTS          = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  obi_req_t               compared_instr_req_i,
    input  obi_req_t               compared_data_req_i,
    input  obi_resp_t              bus_instr_resp_i,
    input  obi_resp_t              bus_data_resp_i,
    output obi_resp_t [NHARTS-1:0] core_instr_resp_o,
    output obi_resp_t [NHARTS-1:0] core_data_resp_o,
    input  logic                   error_i,
    input  logic                   clear_i,
    output logic                   fault_o,
    output logic                   drained_o,
    output logic                   protocol_err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    dmr_rsp_state_e state_q, state_d;

    logic i_spur, i_ovf, i_zero_next;
    logic d_spur, d_ovf, d_zero_next;
    logic [CW-1:0] unused_i_count, unused_d_count;
    logic unused_i_zero, unused_d_zero;
    logic unused_req;
    logic fwd;
    logic perr_q;
    obi_resp_t instr_fwd, data_fwd;

    assign unused_req = ^{compared_instr_req_i, compared_data_req_i};

    dmr_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_instr_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (compared_instr_req_i.req & bus_instr_resp_i.gnt),
        .dec_i       (bus_instr_resp_i.rvalid),
        .count_o     (unused_i_count),
        .zero_o      (unused_i_zero),
        .zero_next_o (i_zero_next),
        .spurious_o  (i_spur),
        .overflow_o  (i_ovf)
    );

    dmr_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_data_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (compared_data_req_i.req & bus_data_resp_i.gnt),
        .dec_i       (bus_data_resp_i.rvalid),
        .count_o     (unused_d_count),
        .zero_o      (unused_d_zero),
        .zero_next_o (d_zero_next),
        .spurious_o  (d_spur),
        .overflow_o  (d_ovf)
    );

    // Next-state: leave RUN on mismatch or overflow, halt once both buses are quiet.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_RUN:   if (error_i || i_ovf || d_ovf) state_d = RSP_DRAIN;
            RSP_DRAIN: if (i_zero_next && d_zero_next) state_d = RSP_HALT;
            RSP_HALT:  if (clear_i) state_d = RSP_RUN;
            default:   state_d = RSP_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RSP_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky protocol error; a new event in the release cycle still wins.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perr_q <= 1'b0;
        end else if (i_spur || d_spur || i_ovf || d_ovf) begin
            perr_q <= 1'b1;
        end else if (state_q == RSP_HALT && clear_i) begin
            perr_q <= 1'b0;
        end
    end

    // Forward only in RUN (or while in reset); the detecting cycle is already gated.
    always_comb begin
        fwd       = ((state_q == RSP_RUN) || !rst_ni) && !(error_i || i_ovf || d_ovf);
        instr_fwd = '0;
        data_fwd  = '0;
        if (fwd) begin
            instr_fwd.gnt = bus_instr_resp_i.gnt;
            data_fwd.gnt  = bus_data_resp_i.gnt;
            if (!i_spur) begin
                instr_fwd.rvalid = bus_instr_resp_i.rvalid;
                instr_fwd.rdata  = bus_instr_resp_i.rdata;
            end
            if (!d_spur) begin
                data_fwd.rvalid = bus_data_resp_i.rvalid;
                data_fwd.rdata  = bus_data_resp_i.rdata;
            end
        end
    end

    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        assign core_instr_resp_o[h] = instr_fwd;
        assign core_data_resp_o[h]  = data_fwd;
    end

    assign fault_o        = (state_q != RSP_RUN);
    assign drained_o      = (state_q == RSP_HALT);
    assign protocol_err_o = perr_q;

endmodule
